riscvssc_rob_ctrl: RTL and testbench
====================================

Name: riscvssc_rob_ctrl

Overview:
In-order allocate/fill/commit controller for the dual-issue core's reorder buffer. Tracks per-slot bookkeeping: valid, ready, wen and waddr.
- Issue stage (I): allocates up to two slots per cycle, A before B.
- Writeback (W): marks up to two slots filled.
- Commit (C): retires up to two oldest ready entries per cycle and drives the commit slot/waddr/wen controls for the datapath ROB data array and register file.

Parameters:
ADDR_W, 5, slot index width; depth DEPTH = 2**ADDR_W (32).
RADDR_W, 5, architectural register address width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  squash all uncommitted entries
alloc_req_A  in  1  I-stage allocation request, instA
alloc_wen_A  in  1  instA writes a register
alloc_waddr_A  in  RADDR_W  instA destination
alloc_req_B  in  1  allocation request, instB (legal only with alloc_req_A)
alloc_wen_B  in  1  instB writes a register
alloc_waddr_B  in  RADDR_W  instB destination
alloc_rdy_A  out  1  at least 1 free slot
alloc_rdy_B  out  1  at least 2 free slots
alloc_slot_A  out  ADDR_W  slot granted to A
alloc_slot_B  out  ADDR_W  slot granted to B
fill_wen_A  in  1  W-stage pipe A result written
fill_slot_A  in  ADDR_W  slot filled by A
fill_wen_B  in  1  W-stage pipe B result written
fill_slot_B  in  ADDR_W  slot filled by B
commit_val_1  out  1  oldest entry retires
commit_wen_1  out  1  oldest entry writes RF
commit_slot_1  out  ADDR_W
commit_waddr_1  out  RADDR_W
commit_val_2  out  1  second-oldest entry retires
commit_wen_2  out  1
commit_slot_2  out  ADDR_W
commit_waddr_2  out  RADDR_W
count  out  ADDR_W+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset clears all state:
  - head = tail = 0, count = 0, all valid/ready = 0.
  - Outputs after reset: alloc_rdy_A = alloc_rdy_B = 1, alloc_slot_A = 0, alloc_slot_B = 1, all commit_* = 0, empty = 1, full = 0.
- Pointers are ADDR_W+1 bits; the slot index is the low ADDR_W bits, and the MSB disambiguates full from empty. Increments wrap modulo 2**(ADDR_W+1).
- Allocation (combinational grant, registered effect):
  - alloc_slot_A = tail; alloc_slot_B = tail+1 (mod DEPTH).
  - free = DEPTH - count, using the registered count only; slots retired this cycle are not reusable until next cycle.
  - alloc_rdy_A = (free >= 1); alloc_rdy_B = (free >= 2).
  - An accepted entry is written valid = 1, ready = 0, wen = alloc_wen & (waddr != 0), waddr.
  - B accepted only if A is also accepted.
  - Tail advances by 0/1/2 at the posedge.
  - alloc_req_B without alloc_req_A: ignored.
- Fill:
  - At the posedge, set ready[fill_slot] if valid[fill_slot].
  - Fill to an invalid slot is ignored.
  - A and B filling the same slot is a single set, not an error.
  - A fill becomes visible to commit the next cycle; there is no fill-to-commit bypass, so minimum fill-to-commit latency is 1 cycle.
- Commit (combinational from registered state):
  - commit_val_1 = valid[head] & ready[head].
  - commit_val_2 = commit_val_1 & valid[head+1] & ready[head+1].
  - commit_wen_n = commit_val_n & wen[slot]; commit_waddr_n = waddr[slot] regardless of val.
  - At the posedge, retired entries are cleared (valid = ready = 0) and head advances by 0/1/2.
  - Commit is strictly in order: a ready entry behind a non-ready head never retires.
- Simultaneous events: count' = count + accepted_allocs - commits. Alloc, fill and commit may target different slots in the same cycle; alloc can never target a currently valid slot.
- Flush:
  - Forces commit_val_1/2 and commit_wen_1/2 to 0 in that cycle.
  - Ignores alloc and fill that cycle.
  - At the posedge: all valid/ready = 0, head = tail = 0, count = 0.
- Reset asserted mid-operation: state clears immediately (asynchronous); in-flight allocs and fills are lost.

Decomposition:
- Shared package riscvssc_rob_pkg: ROB_ADDR_W, ROB_DEPTH, RADDR_W constants, plus an entry struct/field layout {valid, ready, wen, waddr}.
- One natural sub-module: riscvssc_rob_ptr, a wrap-around pointer register with +0/+1/+2 increment and synchronous clear. Instantiated twice, for head and tail.

Test Plan:
- Reset then idle -> alloc_rdy_A = 1, alloc_rdy_B = 1, alloc_slot_A = 0, alloc_slot_B = 1, empty = 1, commit_val_1 = 0.
- Dual alloc (A wen waddr = 3, B wen waddr = 7); fill slot 1 at cycle 2, fill slot 0 at cycle 3 -> nothing commits at cycles 2–3; at cycle 4 commit_val_1/2 = 1, slots 0/1, waddr 3/7, count 2 -> 0.
- Allocate 31 single entries -> alloc_rdy_B = 0 and alloc_rdy_A = 1. Allocate 1 more -> full = 1, alloc_rdy_A = 0, and a request that cycle is not accepted.
- Wrap-around: with head = 30, tail = 30, dual alloc -> slots 30/31. Next dual alloc -> slots 0/1. Fill all four -> commits in order 30, 31, then 0, 1.
- Alloc with alloc_waddr_A = 0 and alloc_wen_A = 1 -> commit_val_1 = 1, commit_wen_1 = 0. Full ROB with head filled and a commit in the same cycle -> alloc_rdy_A stays 0 that cycle and returns to 1 the next.
- Flush with 5 valid, 3 ready entries at the head -> commit_val_1/2 = 0 that cycle; next cycle count = 0, empty = 1, alloc_slot_A = 0.

Source files
------------

// File: rtl/riscvssc_rob_ctrl_pkg.sv
// Shared constants and entry layout for the reorder-buffer controller.
package riscvssc_rob_pkg;

  localparam int ROB_ADDR_W = 5;
  localparam int ROB_DEPTH  = 2 ** ROB_ADDR_W;
  localparam int RADDR_W    = 5;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic               wen;
    logic [RADDR_W-1:0] waddr;
  } rob_entry_t;

endpackage

// File: rtl/riscvssc_rob_ctrl_if.sv
// Issue/writeback/commit signal bundle between the pipeline and the ROB controller.
interface riscvssc_rob_ctrl_if #(
  parameter int ADDR_W  = riscvssc_rob_pkg::ROB_ADDR_W,
  parameter int RADDR_W = riscvssc_rob_pkg::RADDR_W
);
  logic               flush;
  logic               alloc_req_A;
  logic               alloc_wen_A;
  logic [RADDR_W-1:0] alloc_waddr_A;
  logic               alloc_req_B;
  logic               alloc_wen_B;
  logic [RADDR_W-1:0] alloc_waddr_B;
  logic               alloc_rdy_A;
  logic               alloc_rdy_B;
  logic [ADDR_W-1:0]  alloc_slot_A;
  logic [ADDR_W-1:0]  alloc_slot_B;
  logic               fill_wen_A;
  logic [ADDR_W-1:0]  fill_slot_A;
  logic               fill_wen_B;
  logic [ADDR_W-1:0]  fill_slot_B;
  logic               commit_val_1;
  logic               commit_wen_1;
  logic [ADDR_W-1:0]  commit_slot_1;
  logic [RADDR_W-1:0] commit_waddr_1;
  logic               commit_val_2;
  logic               commit_wen_2;
  logic [ADDR_W-1:0]  commit_slot_2;
  logic [RADDR_W-1:0] commit_waddr_2;
  logic [ADDR_W:0]    count;
  logic               full;
  logic               empty;

  modport master (
    output flush, alloc_req_A, alloc_wen_A, alloc_waddr_A,
           alloc_req_B, alloc_wen_B, alloc_waddr_B,
           fill_wen_A, fill_slot_A, fill_wen_B, fill_slot_B,
    input  alloc_rdy_A, alloc_rdy_B, alloc_slot_A, alloc_slot_B,
           commit_val_1, commit_wen_1, commit_slot_1, commit_waddr_1,
           commit_val_2, commit_wen_2, commit_slot_2, commit_waddr_2,
           count, full, empty
  );

  modport slave (
    input  flush, alloc_req_A, alloc_wen_A, alloc_waddr_A,
           alloc_req_B, alloc_wen_B, alloc_waddr_B,
           fill_wen_A, fill_slot_A, fill_wen_B, fill_slot_B,
    output alloc_rdy_A, alloc_rdy_B, alloc_slot_A, alloc_slot_B,
           commit_val_1, commit_wen_1, commit_slot_1, commit_waddr_1,
           commit_val_2, commit_wen_2, commit_slot_2, commit_waddr_2,
           count, full, empty
  );
endinterface

// File: rtl/riscvssc_rob_ctrl_ptr.sv
// Wrap-around ROB pointer with an extra MSB lap bit, +0/+1/+2 step and sync clear.
module riscvssc_rob_ptr #(
  parameter int W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [1:0] inc,
  output logic [W:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else begin
      ptr <= ptr + (W+1)'(inc);
    end
  end

endmodule

// File: rtl/riscvssc_rob_ctrl.sv
// In-order allocate/fill/commit bookkeeping for the dual-issue reorder buffer.
module riscvssc_rob_ctrl #(
  parameter int ADDR_W  = riscvssc_rob_pkg::ROB_ADDR_W,
  parameter int RADDR_W = riscvssc_rob_pkg::RADDR_W
) (
  input logic                clk,
  input logic                reset,
  riscvssc_rob_ctrl_if.slave rob
);
  import riscvssc_rob_pkg::*;

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  rob_entry_t        ent_q [DEPTH];
  logic [ADDR_W:0]   head, tail, count_q;
  logic [ADDR_W-1:0] h0, h1, t0, t1;
  logic              rdy_a, rdy_b, acc_a, acc_b, cv1, cv2;
  logic [1:0]        n_alloc, n_commit;

  assign h0 = head[ADDR_W-1:0];
  assign h1 = h0 + ADDR_W'(1);
  assign t0 = tail[ADDR_W-1:0];
  assign t1 = t0 + ADDR_W'(1);

  // Free space comes from the registered count only: slots retiring this cycle are not reusable yet.
  assign rdy_a = count_q < DEPTH_C;
  assign rdy_b = count_q < (DEPTH_C - (ADDR_W+1)'(1));
  assign acc_a = ~rob.flush & rob.alloc_req_A & rdy_a;
  assign acc_b = acc_a & rob.alloc_req_B & rdy_b;

  assign cv1 = ~rob.flush & ent_q[h0].valid & ent_q[h0].ready;
  assign cv2 = cv1 & ent_q[h1].valid & ent_q[h1].ready;

  assign n_alloc  = {acc_b, acc_a & ~acc_b};
  assign n_commit = {cv2, cv1 & ~cv2};

  assign rob.alloc_rdy_A    = rdy_a;
  assign rob.alloc_rdy_B    = rdy_b;
  assign rob.alloc_slot_A   = t0;
  assign rob.alloc_slot_B   = t1;
  assign rob.commit_val_1   = cv1;
  assign rob.commit_wen_1   = cv1 & ent_q[h0].wen;
  assign rob.commit_slot_1  = h0;
  assign rob.commit_waddr_1 = ent_q[h0].waddr;
  assign rob.commit_val_2   = cv2;
  assign rob.commit_wen_2   = cv2 & ent_q[h1].wen;
  assign rob.commit_slot_2  = h1;
  assign rob.commit_waddr_2 = ent_q[h1].waddr;
  assign rob.count          = count_q;
  assign rob.full           = count_q == DEPTH_C;
  assign rob.empty          = count_q == '0;

  riscvssc_rob_ptr #(.W(ADDR_W)) u_head (
    .clk(clk), .reset(reset), .clr(rob.flush), .inc(n_commit), .ptr(head)
  );

  riscvssc_rob_ptr #(.W(ADDR_W)) u_tail (
    .clk(clk), .reset(reset), .clr(rob.flush), .inc(n_alloc), .ptr(tail)
  );

  // Commit clears are ordered after fills so a late fill cannot resurrect a retired slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else if (rob.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].ready <= 1'b0;
      end
      count_q <= '0;
    end else begin
      if (rob.fill_wen_A && ent_q[rob.fill_slot_A].valid) ent_q[rob.fill_slot_A].ready <= 1'b1;
      if (rob.fill_wen_B && ent_q[rob.fill_slot_B].valid) ent_q[rob.fill_slot_B].ready <= 1'b1;
      if (cv1) begin
        ent_q[h0].valid <= 1'b0;
        ent_q[h0].ready <= 1'b0;
      end
      if (cv2) begin
        ent_q[h1].valid <= 1'b0;
        ent_q[h1].ready <= 1'b0;
      end
      if (acc_a) begin
        ent_q[t0] <= '{valid: 1'b1, ready: 1'b0,
                       wen:   rob.alloc_wen_A & (rob.alloc_waddr_A != RADDR_W'(0)),
                       waddr: rob.alloc_waddr_A};
      end
      if (acc_b) begin
        ent_q[t1] <= '{valid: 1'b1, ready: 1'b0,
                       wen:   rob.alloc_wen_B & (rob.alloc_waddr_B != RADDR_W'(0)),
                       waddr: rob.alloc_waddr_B};
      end
      count_q <= count_q + (ADDR_W+1)'(n_alloc) - (ADDR_W+1)'(n_commit);
    end
  end

endmodule

// File: tb/tb_riscvssc_rob_ctrl.sv
// Scoreboard bench: a queue-based ROB model predicts each cycle's outputs, a negedge monitor compares.
module tb_riscvssc_rob_ctrl;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  riscvssc_rob_ctrl_if #(.ADDR_W(AW), .RADDR_W(5)) rob ();

  riscvssc_rob_ctrl #(.ADDR_W(AW), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .rob(rob)
  );

  typedef struct {
    int       slot;
    bit       wen;
    bit [4:0] waddr;
    bit       ready;
  } ment_t;

  typedef struct {
    bit       rdy_a, rdy_b, full, empty, c1, c2, w1, w2;
    int       slot_a, slot_b, count, s1, s2;
    bit [4:0] a1, a2;
  } exp_t;

  ment_t mq[$];
  int    m_head = 0;
  int    m_tail = 0;
  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;

  bit       i_rst, i_fl, i_ra, i_wa, i_rb, i_wb, i_fa, i_fb;
  bit [4:0] i_aa, i_ab, i_sa, i_sb;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {i_rst, i_fl, i_ra, i_wa, i_rb, i_wb, i_fa, i_fb} = '0;
    i_aa = '0; i_ab = '0; i_sa = '0; i_sb = '0;
  endtask

  // One cycle: drive i_*, predict this cycle's outputs, then advance the model.
  task automatic step();
    exp_t  e;
    ment_t ne;
    int    n, c;
    @(posedge clk); #1;
    reset             = i_rst;
    rob.flush         = i_fl;
    rob.alloc_req_A   = i_ra; rob.alloc_wen_A = i_wa; rob.alloc_waddr_A = i_aa;
    rob.alloc_req_B   = i_rb; rob.alloc_wen_B = i_wb; rob.alloc_waddr_B = i_ab;
    rob.fill_wen_A    = i_fa; rob.fill_slot_A = i_sa;
    rob.fill_wen_B    = i_fb; rob.fill_slot_B = i_sb;
    if (i_rst) begin
      mq.delete(); m_head = 0; m_tail = 0;
    end
    n        = mq.size();
    e.rdy_a  = n < DEPTH;
    e.rdy_b  = n <= DEPTH - 2;
    e.slot_a = m_tail;
    e.slot_b = (m_tail + 1) % DEPTH;
    e.count  = n;
    e.full   = n == DEPTH;
    e.empty  = n == 0;
    e.c1     = !i_fl && n >= 1 && mq[0].ready;
    e.c2     = e.c1 && n >= 2 && mq[1].ready;
    e.w1     = e.c1 && mq[0].wen;
    e.w2     = e.c2 && mq[1].wen;
    e.a1     = e.c1 ? mq[0].waddr : 5'd0;
    e.a2     = e.c2 ? mq[1].waddr : 5'd0;
    e.s1     = m_head;
    e.s2     = (m_head + 1) % DEPTH;
    expq.push_back(e);
    if (i_rst) begin
    end else if (i_fl) begin
      mq.delete(); m_head = 0; m_tail = 0;
    end else begin
      foreach (mq[i])
        if ((i_fa && mq[i].slot == int'(i_sa)) || (i_fb && mq[i].slot == int'(i_sb))) mq[i].ready = 1'b1;
      c = int'(e.c1) + int'(e.c2);
      repeat (c) void'(mq.pop_front());
      m_head = (m_head + c) % DEPTH;
      if (i_ra && n < DEPTH) begin
        ne.slot = m_tail; ne.wen = i_wa && i_aa != 0; ne.waddr = i_aa; ne.ready = 1'b0;
        mq.push_back(ne);
        m_tail = (m_tail + 1) % DEPTH;
        if (i_rb && n <= DEPTH - 2) begin
          ne.slot = m_tail; ne.wen = i_wb && i_ab != 0; ne.waddr = i_ab; ne.ready = 1'b0;
          mq.push_back(ne);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
    clear_inputs();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("alloc_rdy_A",  int'(rob.alloc_rdy_A),  int'(e.rdy_a));
      chk("alloc_rdy_B",  int'(rob.alloc_rdy_B),  int'(e.rdy_b));
      chk("alloc_slot_A", int'(rob.alloc_slot_A), e.slot_a);
      chk("alloc_slot_B", int'(rob.alloc_slot_B), e.slot_b);
      chk("count",        int'(rob.count),        e.count);
      chk("full",         int'(rob.full),         int'(e.full));
      chk("empty",        int'(rob.empty),        int'(e.empty));
      chk("commit_val_1", int'(rob.commit_val_1), int'(e.c1));
      chk("commit_val_2", int'(rob.commit_val_2), int'(e.c2));
      chk("commit_wen_1", int'(rob.commit_wen_1), int'(e.w1));
      chk("commit_wen_2", int'(rob.commit_wen_2), int'(e.w2));
      chk("commit_slot_1", int'(rob.commit_slot_1), e.s1);
      chk("commit_slot_2", int'(rob.commit_slot_2), e.s2);
      if (e.c1) chk("commit_waddr_1", int'(rob.commit_waddr_1), int'(e.a1));
      if (e.c2) chk("commit_waddr_2", int'(rob.commit_waddr_2), int'(e.a2));
    end
  end

  initial begin
    clear_inputs();
    rob.flush = 1'b0;
    rob.alloc_req_A = 1'b0; rob.alloc_wen_A = 1'b0; rob.alloc_waddr_A = '0;
    rob.alloc_req_B = 1'b0; rob.alloc_wen_B = 1'b0; rob.alloc_waddr_B = '0;
    rob.fill_wen_A = 1'b0; rob.fill_slot_A = '0;
    rob.fill_wen_B = 1'b0; rob.fill_slot_B = '0;

    i_rst = 1'b1; step();
    step();

    // dual alloc, out-of-order fill, paired commit
    i_ra = 1; i_wa = 1; i_aa = 5'd3; i_rb = 1; i_wb = 1; i_ab = 5'd7; step();
    i_fa = 1; i_sa = 5'd1; step();
    i_fb = 1; i_sb = 5'd0; step();
    step(); step();

    // fill the ROB to the brim, then probe full-cycle behaviour
    repeat (31) begin i_ra = 1; i_wa = 1; i_aa = 5'($urandom); step(); end
    i_ra = 1; i_wa = 1; i_aa = 5'd9; step();
    i_ra = 1; i_rb = 1; i_aa = 5'd11; step();
    i_fa = 1; i_sa = 5'(m_head); step();
    i_ra = 1; i_wa = 1; i_aa = 5'd12; step();
    i_ra = 1; i_wa = 1; i_aa = 5'd13; step();

    // flush with 5 valid / 3 ready at head
    i_fl = 1; step();
    i_ra = 1; i_rb = 1; i_wa = 1; i_aa = 5'd1; i_wb = 1; i_ab = 5'd2; step();
    i_ra = 1; i_rb = 1; i_wa = 1; i_aa = 5'd3; i_wb = 1; i_ab = 5'd4; step();
    i_ra = 1; i_wa = 1; i_aa = 5'd5; i_fa = 1; i_sa = 5'd1; i_fb = 1; i_sb = 5'd2; step();
    i_fa = 1; i_sa = 5'd0; step();
    i_fl = 1; step();
    step();

    // x0 destination never writes, even with wen set
    i_ra = 1; i_wa = 1; i_aa = 5'd0; step();
    i_fa = 1; i_sa = 5'd0; step();
    step();

    // walk pointers to 30, then straddle the wrap
    i_fl = 1; step();
    repeat (15) begin
      i_ra = 1; i_rb = 1; i_wa = 1; i_aa = 5'($urandom); i_wb = 1; i_ab = 5'($urandom); step();
      i_fa = 1; i_sa = 5'(m_head); i_fb = 1; i_sb = 5'((m_head + 1) % DEPTH); step();
      step();
    end
    i_ra = 1; i_rb = 1; i_wa = 1; i_aa = 5'd21; i_wb = 1; i_ab = 5'd22; step();
    i_ra = 1; i_rb = 1; i_wa = 1; i_aa = 5'd23; i_wb = 1; i_ab = 5'd24; step();
    i_fa = 1; i_sa = 5'd30; i_fb = 1; i_sb = 5'd31; step();
    i_fa = 1; i_sa = 5'd0;  i_fb = 1; i_sb = 5'd1;  step();
    step(); step();

    // reset lands on an in-flight alloc
    i_ra = 1; i_rb = 1; i_aa = 5'd6; i_ab = 5'd8; step();
    i_rst = 1; i_ra = 1; i_fa = 1; i_sa = 5'd0; step();
    step();

    for (int k = 0; k < 3000; k++) begin
      int fill_pct;
      fill_pct = ((k / 200) % 2 == 0) ? 75 : 15;
      i_ra = ($urandom_range(99) < 60);
      i_rb = ($urandom_range(99) < 50);
      i_wa = $urandom_range(1); i_aa = 5'($urandom);
      i_wb = $urandom_range(1); i_ab = 5'($urandom);
      i_fa = ($urandom_range(99) < fill_pct);
      i_fb = ($urandom_range(99) < fill_pct);
      if (mq.size() > 0 && $urandom_range(99) < 85) i_sa = 5'(mq[$urandom_range(mq.size() - 1)].slot);
      else i_sa = 5'($urandom);
      if (mq.size() > 0 && $urandom_range(99) < 85) i_sb = 5'(mq[$urandom_range(mq.size() - 1)].slot);
      else i_sb = 5'($urandom);
      i_fl  = ($urandom_range(63) == 0);
      i_rst = ($urandom_range(499) == 0);
      step();
    end

    step();
    @(negedge clk); #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
